// File: rtl/segway_pkg.sv
// Shared types and constants for the Segway balance-path control blocks.
package segway_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        STEER = 2'd2
    } steer_state_t;

    localparam logic [11:0] MIN_RIDER_WT_DEF = 12'h200;
    localparam logic [11:0] WT_HYST_DEF      = 12'h40;

    localparam int TMR_W_SIM  = 15;
    localparam int TMR_W_FULL = 26;

endpackage

// File: rtl/steer_tmr.sv
// Clearable saturating settle timer; width is 15 bits when FAST_SIM, else 26 bits.
module steer_tmr
    import segway_pkg::*;
#(
    parameter int FAST_SIM = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_tmr,
    output logic       tmr_full,
    output logic [7:0] tmr_dbg
);

    localparam int TMR_W = (FAST_SIM != 0) ? TMR_W_SIM : TMR_W_FULL;

    logic [TMR_W-1:0] tmr_q;
    logic [TMR_W-1:0] tmr_d;

    assign tmr_full = &tmr_q;
    assign tmr_dbg  = tmr_q[TMR_W-1 -: 8];

    // Clear wins; otherwise count up and park at all-ones.
    always_comb begin
        tmr_d = tmr_q;
        if (clr_tmr) begin
            tmr_d = '0;
        end else if (!tmr_full) begin
            tmr_d = tmr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

endmodule

// File: rtl/steer_en.sv
// Rider-presence hysteresis and steering-enable sequencer.
// Define STEER_EN_LD_AVG_EN to 2-tap average each load cell before thresholding.
module steer_en
    import segway_pkg::*;
#(
    parameter int          FAST_SIM     = 1,
    parameter logic [11:0] MIN_RIDER_WT = MIN_RIDER_WT_DEF,
    parameter logic [11:0] WT_HYST      = WT_HYST_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        en_steer,
    output logic        rider_off,
    output logic [7:0]  tmr_dbg
);

    localparam logic [12:0] ON_THR  = 13'(MIN_RIDER_WT) + 13'(WT_HYST);
    localparam logic [12:0] OFF_THR = 13'(MIN_RIDER_WT) - 13'(WT_HYST);

    function automatic logic [11:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    logic [11:0] lft_use;
    logic [11:0] rght_use;

`ifdef STEER_EN_LD_AVG_EN
    logic [11:0] lft_prev_q, rght_prev_q;
    logic [11:0] lft_avg_q,  rght_avg_q;
    logic [11:0] lft_avg_d,  rght_avg_d;

    // Average is registered so every decision sees exactly one extra clk of latency.
    always_comb begin
        lft_avg_d  = 12'((13'(lft_ld)  + 13'(lft_prev_q))  >> 1);
        rght_avg_d = 12'((13'(rght_ld) + 13'(rght_prev_q)) >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_prev_q  <= '0;
            rght_prev_q <= '0;
            lft_avg_q   <= '0;
            rght_avg_q  <= '0;
        end else begin
            lft_prev_q  <= lft_ld;
            rght_prev_q <= rght_ld;
            lft_avg_q   <= lft_avg_d;
            rght_avg_q  <= rght_avg_d;
        end
    end

    assign lft_use  = lft_avg_q;
    assign rght_use = rght_avg_q;
`else
    assign lft_use  = lft_ld;
    assign rght_use = rght_ld;
`endif

    logic [12:0] sum_ld;
    logic [11:0] diff;
    logic        rider_on, rider_gone, diff_1_4, diff_15_16;

    assign sum_ld     = 13'(lft_use) + 13'(rght_use);
    assign diff       = abs_diff(lft_use, rght_use);
    assign rider_on   = sum_ld > ON_THR;
    assign rider_gone = sum_ld < OFF_THR;
    assign diff_1_4   = 13'(diff) > (sum_ld >> 2);
    assign diff_15_16 = 13'(diff) > (sum_ld - (sum_ld >> 4));

    steer_state_t state_q, state_d;
    logic         en_steer_q, en_steer_d;
    logic         rider_off_q, rider_off_d;
    logic         clr_tmr;
    logic         tmr_full;

    steer_tmr #(
        .FAST_SIM (FAST_SIM)
    ) u_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_tmr  (clr_tmr),
        .tmr_full (tmr_full),
        .tmr_dbg  (tmr_dbg)
    );

    // Rider leaving outranks balance checks, which outrank settle completion.
    always_comb begin
        state_d = state_q;
        clr_tmr = 1'b0;
        case (state_q)
            IDLE: begin
                if (rider_on) begin
                    state_d = WAIT;
                    clr_tmr = 1'b1;
                end
            end
            WAIT: begin
                if (rider_gone) begin
                    state_d = IDLE;
                end else if (diff_1_4) begin
                    clr_tmr = 1'b1;
                end else if (tmr_full) begin
                    state_d = STEER;
                end
            end
            STEER: begin
                if (rider_gone) begin
                    state_d = IDLE;
                end else if (diff_15_16) begin
                    state_d = WAIT;
                    clr_tmr = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        en_steer_d  = (state_d == STEER);
        rider_off_d = rider_off_q;
        if (rider_gone) begin
            rider_off_d = 1'b1;
        end else if (rider_on) begin
            rider_off_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            en_steer_q  <= 1'b0;
            rider_off_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            en_steer_q  <= en_steer_d;
            rider_off_q <= rider_off_d;
        end
    end

    assign en_steer  = en_steer_q;
    assign rider_off = rider_off_q;

endmodule
